// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Shares the single data-cache port between the instruction-fetch requester (IF)
//   and the memory-stage requester (MEM). The winning request is latched at grant,
//   one cache command is issued, the hit flag is checked, and the command is
//   re-issued on a miss until it hits or MAX_RETRY re-issues are used up (which
//   completes with err). Completion is a one-cycle done pulse to the owner.
//
//   Configuration macro: RR_ARB_EN
//     defined   -> round-robin between simultaneous requesters
//     undefined -> fixed priority, MEM always beats IF
//
//   Ports
//     clk, reset                clock and synchronous active-high reset
//     if_req/if_addr            IF read request (level) and address
//     if_rdata/if_done/if_stall IF read data, completion pulse, stall
//     mem_op/mem_addr/mem_wdata MEM request (01 read, 10 write), address, store data
//     mem_rdata/mem_done/mem_stall MEM load data, completion pulse, stall
//     err                       pulses with done when the retry limit is exhausted
//     cache_read/cache_write    one-cycle cache commands
//     cache_address/cache_data_in latched address and store data to the cache
//     cache_data_out/cache_hit  cache read data and hit flag, sampled in CHECK

module cache_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic [1:0]    mem_op,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          mem_stall,
  output logic          err,
  output logic          cache_read,
  output logic          cache_write,
  output logic [AW-1:0] cache_address,
  output logic [DW-1:0] cache_data_in,
  input  logic [DW-1:0] cache_data_out,
  input  logic          cache_hit
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

  logic [1:0] state;
  logic       owner_mem;
  logic       op_write;
  logic [7:0] retry;
  logic       mem_valid;
  logic       if_cand;
  logic       mem_cand;
  logic       grant_mem;
  logic       grant_write;

`ifdef RR_ARB_EN
  logic       last_mem;
`endif

  // A requester whose done pulse is high this cycle is still holding its request;
  // it must not be granted again until the following cycle.
  always_comb begin
    mem_valid   = (mem_op == 2'b01) | (mem_op == 2'b10);
    if_cand     = if_req & ~if_done;
    mem_cand    = mem_valid & ~mem_done;
`ifdef RR_ARB_EN
    grant_mem   = mem_cand & (~if_cand | ~last_mem);
`else
    grant_mem   = mem_cand;
`endif
    grant_write = grant_mem & (mem_op == 2'b10);
  end

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_valid & ~mem_done;

  // Main FSM. Commands, done and err are registered and default low so each is a
  // single-cycle pulse; the command for an ISSUE cycle is set on the edge entering it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner_mem     <= 1'b0;
      op_write      <= 1'b0;
      retry         <= '0;
      if_rdata      <= '0;
      mem_rdata     <= '0;
      if_done       <= 1'b0;
      mem_done      <= 1'b0;
      err           <= 1'b0;
      cache_read    <= 1'b0;
      cache_write   <= 1'b0;
      cache_address <= '0;
      cache_data_in <= '0;
`ifdef RR_ARB_EN
      last_mem      <= 1'b0;
`endif
    end else begin
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      err         <= 1'b0;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_cand | mem_cand) begin
            owner_mem     <= grant_mem;
            op_write      <= grant_write;
            cache_address <= grant_mem ? mem_addr : if_addr;
            if (grant_mem) begin
              cache_data_in <= mem_wdata;
            end
            retry         <= '0;
            cache_read    <= ~grant_write;
            cache_write   <= grant_write;
`ifdef RR_ARB_EN
            last_mem      <= grant_mem;
`endif
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (cache_hit) begin
            if_done  <= ~owner_mem;
            mem_done <= owner_mem;
            if (!op_write) begin
              if (owner_mem) begin
                mem_rdata <= cache_data_out;
              end else begin
                if_rdata <= cache_data_out;
              end
            end
            state <= ST_IDLE;
          end else if (retry < RETRY_LIMIT) begin
            retry       <= retry + 8'd1;
            cache_read  <= ~op_write;
            cache_write <= op_write;
            state       <= ST_ISSUE;
          end else begin
            // Retry budget exhausted: complete with error, read data untouched.
            if_done  <= ~owner_mem;
            mem_done <= owner_mem;
            err      <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter
//   Randomized bench for cache_port_arbiter. A transaction-level reference model
//   predicts, from the grant cycle and the planned number of misses, when each
//   cache command and done pulse must appear, what data is returned and which
//   requester wins. The bench also plays the cache: it drives cache_hit in each
//   predicted CHECK cycle according to the plan and random values elsewhere.
//   One mid-transaction reset is applied during a CHECK cycle.

module tb_cache_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 15;
  localparam int NCYC = 3000;
  localparam int RSTAT = 1500;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic [1:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_stall;
  logic          err;
  logic          cache_read;
  logic          cache_write;
  logic [AW-1:0] cache_address;
  logic [DW-1:0] cache_data_in;
  logic [DW-1:0] cache_data_out;
  logic          cache_hit;

  always #5 clk = ~clk;

  cache_port_arbiter #(.AW(AW), .DW(DW), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .err(err), .cache_read(cache_read), .cache_write(cache_write),
    .cache_address(cache_address), .cache_data_in(cache_data_in),
    .cache_data_out(cache_data_out), .cache_hit(cache_hit)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: the transaction in flight
  int          t;
  bit          busy;
  int          owner;       // 0 = IF, 1 = MEM
  int          g;           // grant cycle
  int          k;           // planned misses before the hit (MAXR+1 means never hits)
  int          doneCycle;
  bit          mWrite;
  logic [31:0] mAddr, mWdata, hitData;
  int          lastGrant;
  logic [31:0] expIfR, expMemR;

  // Requester state
  bit          ifPend, ifGranted, ifDrop;
  logic [31:0] ifA;
  bit          memPend, memGranted, memDrop, memWr;
  logic [31:0] memA, memW;

  // Expectations for the current cycle
  bit expRd, expWr, expIfDone, expMemDone, expErr;
  int compl;
  bit rstPending, rstDone;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want)
      $display("[TB] FAIL %s at cycle %0d: got %h want %h", tag, t, got, want);
    else
      passCount++;
  endtask

  task automatic modelReset();
    busy = 0; lastGrant = 0; expIfR = '0; expMemR = '0;
    ifPend = 0; ifGranted = 0; ifDrop = 0;
    memPend = 0; memGranted = 0; memDrop = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_done"},   if_done, 0);
    checkOutput({tag, "_mem_done"},  mem_done, 0);
    checkOutput({tag, "_err"},       err, 0);
    checkOutput({tag, "_rd"},        cache_read, 0);
    checkOutput({tag, "_wr"},        cache_write, 0);
    checkOutput({tag, "_addr"},      cache_address, 0);
    checkOutput({tag, "_data_in"},   cache_data_in, 0);
    checkOutput({tag, "_if_rdata"},  if_rdata, 0);
    checkOutput({tag, "_mem_rdata"}, mem_rdata, 0);
  endtask

  // Work out what the registered outputs must be in cycle t and retire a
  // transaction whose completion cycle has arrived.
  task automatic predictOutputs();
    int d;
    expRd = 0; expWr = 0; expIfDone = 0; expMemDone = 0; expErr = 0; compl = -1;
    if (busy) begin
      d = t - g;
      if (t == doneCycle) begin
        expErr = (k > MAXR);
        if (owner == 0) begin expIfDone = 1; ifDrop = 1; end
        else begin expMemDone = 1; memDrop = 1; end
        if (!expErr && !mWrite) begin
          if (owner == 0) expIfR = hitData; else expMemR = hitData;
        end
        compl = owner;
        busy = 0;
      end else if (d % 2 == 1) begin
        expRd = !mWrite;
        expWr = mWrite;
      end
    end
    checkOutput("cache_read",  cache_read, expRd);
    checkOutput("cache_write", cache_write, expWr);
    checkOutput("if_done",     if_done, expIfDone);
    checkOutput("mem_done",    mem_done, expMemDone);
    checkOutput("err",         err, expErr);
    checkOutput("mem_rdata",   mem_rdata, expMemR);
    if (expIfDone) checkOutput("if_rdata", if_rdata, expIfR);
    if (expRd || expWr) checkOutput("cache_address", cache_address, mAddr);
    if (expWr) checkOutput("cache_data_in", cache_data_in, mWdata);
  endtask

  // Requester behaviour and cache responder for cycle t.
  task automatic applyStimulus();
    int d;
    if (ifDrop && compl != 0) begin ifDrop = 0; ifPend = 0; ifGranted = 0; end
    if (memDrop && compl != 1) begin memDrop = 0; memPend = 0; memGranted = 0; end
    if (!ifPend && $urandom_range(0, 3) == 0) begin
      ifPend = 1; ifGranted = 0; ifA = $urandom;
    end
    if (!memPend && $urandom_range(0, 1) == 0) begin
      memPend = 1; memGranted = 0; memA = $urandom; memW = $urandom;
      memWr = ($urandom_range(0, 1) == 1);
    end
    if_req    = ifPend;
    if_addr   = (ifPend && !ifGranted) ? ifA : $urandom;
    mem_op    = memPend ? (memWr ? 2'b10 : 2'b01) : (($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00);
    mem_addr  = (memPend && !memGranted) ? memA : $urandom;
    mem_wdata = (memPend && !memGranted) ? memW : $urandom;
    cache_data_out = $urandom;
    cache_hit = 1'($urandom_range(0, 1));
    if (busy) begin
      d = t - g;
      if (d >= 2 && d % 2 == 0) begin
        cache_hit = ((d - 2) / 2 == k);
        if (cache_hit) hitData = cache_data_out;
      end
    end
  endtask

  // Grant decision in an idle cycle; the completing requester still holds its
  // granted flag, so it is excluded automatically.
  task automatic arbitrate();
    bit cIf, cMem;
    if (busy) return;
    cIf  = ifPend && !ifGranted;
    cMem = memPend && !memGranted;
    if (!(cIf || cMem)) return;
`ifdef RR_ARB_EN
    if (cIf && cMem) owner = (lastGrant == 1) ? 0 : 1;
    else owner = cMem ? 1 : 0;
`else
    owner = cMem ? 1 : 0;
`endif
    k = ($urandom_range(0, 9) == 0) ? MAXR + 1 : $urandom_range(0, 2);
    g = t;
    doneCycle = g + 3 + 2 * ((k > MAXR) ? MAXR : k);
    if (owner == 1) begin
      mAddr = memA; mWrite = memWr; mWdata = memW; memGranted = 1;
    end else begin
      mAddr = ifA; mWrite = 0; ifGranted = 1;
    end
    lastGrant = owner;
    busy = 1;
  endtask

  task automatic checkStalls();
    checkOutput("if_stall",  if_stall, ifPend && !expIfDone);
    checkOutput("mem_stall", mem_stall, memPend && !expMemDone);
  endtask

  initial begin
    reset = 1; if_req = 0; if_addr = '0; mem_op = 2'b00; mem_addr = '0;
    mem_wdata = '0; cache_data_out = '0; cache_hit = 0;
    t = 0; rstDone = 0; rstPending = 0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 0;
    modelReset();
    for (int n = 0; n < NCYC; n++) begin
      if (rstPending) begin
        rstPending = 0;
        reset = 0;
        checkAllZero("midreset");
        modelReset();
      end
      predictOutputs();
      applyStimulus();
      arbitrate();
      #1;
      checkStalls();
      if (!rstDone && t >= RSTAT && busy && (t - g) >= 2 && ((t - g) % 2 == 0)) begin
        reset = 1; rstPending = 1; rstDone = 1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!rstDone) checkOutput("reset_applied", 0, 1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
